// File: rtl/uart_pkg.sv
// Shared UART types: FSM state encoding and baud arithmetic helpers.
// UART_RX_PARITY_EN widens the state to 3 bits and adds PARITY.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;
`endif

  function automatic int bit_cyc_f(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

  function automatic int cnt_w_f(input int bit_cyc);
    return (bit_cyc < 2) ? 1 : $clog2(bit_cyc);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Received-byte valid/ready bundle.
// master: o_data/o_valid out, i_ready in. slave: the consumer side.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;

  modport master (
    output o_data,
    output o_valid,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    output i_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period tick counter. load: first tick BIT_CYC/2 cycles later,
// then every BIT_CYC. clr (lower priority than load) holds it idle.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BIT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_w_f(BIT_CYC);

  logic [CW-1:0] cnt;
  logic          run;

  assign tick = run && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || (clr && !load)) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= CW'(BIT_CYC / 2 - 1);
      run <= 1'b1;
    end else if (tick) begin
      cnt <= CW'(BIT_CYC - 1);
    end else if (run) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop sync, mid-bit sampling, LSB-first shift, stop check.
// Ports: clk, rst, i_rx, rx_if (master: o_data/o_valid/i_ready),
// o_busy, o_frame_err, o_overrun, o_parity_err. Option: UART_RX_PARITY_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_rx,
  uart_rx_ctrl_if.master  rx_if,
  output logic            o_busy,
  output logic            o_frame_err,
  output logic            o_overrun,
  output logic            o_parity_err
);

  localparam int BIT_CYC = bit_cyc_f(CLK_FREQ, BAUD_RATE);
  localparam int IW      = $clog2(DATA_BITS + 1);

`ifdef UART_RX_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
`else
  localparam state_e AFTER_DATA = STOP;
`endif

  if (BIT_CYC < 4) begin : g_bad_baud
    $error("uart_rx_ctrl: BIT_CYC must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_width
    $error("uart_rx_ctrl: DATA_BITS must be 5..8");
  end

  logic                 rx_q1;
  logic                 rx_s;
  logic                 rx_p;
  state_e               state;
  logic [DATA_BITS-1:0] sh;
  logic [IW-1:0]        idx;
  logic                 tick;
  logic                 load;
  logic                 clr;
  logic                 par_bad;

  assign load = (state == IDLE) && rx_p && !rx_s;
  assign clr  = (state == IDLE);

  uart_baud_tick #(
    .BIT_CYC (BIT_CYC)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .clr  (clr),
    .tick (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_bad = par_bit ^ (^sh);
`else
  assign par_bad      = 1'b0;
  assign o_parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q1         <= 1'b1;
      rx_s          <= 1'b1;
      rx_p          <= 1'b1;
      state         <= IDLE;
      sh            <= '0;
      idx           <= '0;
      rx_if.o_data  <= '0;
      rx_if.o_valid <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_err   <= 1'b0;
      o_overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit       <= 1'b0;
      o_parity_err  <= 1'b0;
`endif
    end else begin
      rx_q1       <= i_rx;
      rx_s        <= rx_q1;
      rx_p        <= rx_s;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      if (rx_if.o_valid && rx_if.i_ready)
        rx_if.o_valid <= 1'b0;
      case (state)
        IDLE: if (load) begin
          state  <= START;
          o_busy <= 1'b1;
        end
        START: if (tick) begin
          if (rx_s) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            state <= DATA;
            idx   <= '0;
          end
        end
        DATA: if (tick) begin
          sh  <= {rx_s, sh[DATA_BITS-1:1]};
          idx <= idx + 1'b1;
          if (idx == IW'(DATA_BITS - 1))
            state <= AFTER_DATA;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          par_bit <= rx_s;
          state   <= STOP;
        end
`endif
        STOP: if (tick) begin
          state       <= IDLE;
          o_busy      <= 1'b0;
          o_frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
          o_parity_err <= par_bad;
`endif
          if (rx_s && !par_bad) begin
            // Unaccepted byte wins; a same-cycle handshake frees the slot.
            if (rx_if.o_valid && !rx_if.i_ready) begin
              o_overrun <= 1'b1;
            end else begin
              rx_if.o_data  <= sh;
              rx_if.o_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl at BIT_CYC=16: per-frame event model plus
// directed literal checks (good, glitch, framing, overrun, reset, parity).
module tb_uart_rx_ctrl;

  localparam int BC = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // i_rx falls at cycle t: sync makes rx_s low at t+2 (edge/load),
  // first tick half a bit later, then start+data+parity+stop ticks.
  localparam int LOAD       = 2;
  localparam int START_TICK = LOAD + BC / 2;
  localparam int STOP_TICK  = START_TICK + BC * (8 + 1 + PB);
  localparam int COMMIT     = STOP_TICK + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_rx = 1'b1;
  logic busy, fe, ov, pe;

  uart_rx_ctrl_if #(.DATA_BITS(8)) u_if ();

  uart_rx_ctrl #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (100_000),
    .DATA_BITS (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (i_rx),
    .rx_if        (u_if.master),
    .o_busy       (busy),
    .o_frame_err  (fe),
    .o_overrun    (ov),
    .o_parity_err (pe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         c;
    logic [7:0] b;
    bit         stop_ok;
    bit         par_bad;
  } ev_t;

  ev_t ev_q[$];
  int  b_from[$];
  int  b_to[$];
  bit  chk_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h",
               nm, cyc, act, exp);
    end
  endtask

  // Model: commits happen at event cycles; valid/ready bookkeeping.
  bit         mv = 1'b0;
  logic [7:0] md = 8'h00;
  bit         rst_prev = 1'b1;
  bit         rdy_prev = 1'b0;

  always @(negedge clk) begin
    bit  e_fe, e_pe, e_ov, e_busy, hs;
    ev_t ev;
    e_fe = 0; e_pe = 0; e_ov = 0; e_busy = 0; hs = 0;
    if (rst_prev) begin
      mv = 0;
      md = 8'h00;
      ev_q.delete();
      b_from.delete();
      b_to.delete();
    end else begin
      hs = mv && rdy_prev;
      if (ev_q.size() != 0 && ev_q[0].c == cyc) begin
        ev   = ev_q.pop_front();
        e_fe = !ev.stop_ok;
        e_pe = ev.par_bad;
        if (ev.stop_ok && !ev.par_bad) begin
          if (mv && !hs) e_ov = 1;
          else begin
            md = ev.b;
            mv = 1;
          end
        end else if (hs) mv = 0;
      end else if (hs) mv = 0;
      foreach (b_from[i])
        if (cyc >= b_from[i] && cyc <= b_to[i]) e_busy = 1;
    end
    if (chk_en) begin
      chk("m_valid", u_if.o_valid, mv);
      if (mv) chk("m_data", u_if.o_data, md);
      chk("m_busy", busy, e_busy);
      chk("m_frame_err", fe, e_fe);
      chk("m_overrun", ov, e_ov);
      chk("m_parity_err", pe, e_pe);
    end
    rst_prev = rst;
    rdy_prev = u_if.i_ready;
  end

  task automatic tick_n(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_cyc(int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic send_frame(logic [7:0] b, bit stop, bit pbit);
    int  t0 = cyc;
    ev_t ev;
    ev.c       = t0 + COMMIT;
    ev.b       = b;
    ev.stop_ok = stop;
    ev.par_bad = (PB != 0) && (pbit != ^b);
    ev_q.push_back(ev);
    b_from.push_back(t0 + LOAD + 1);
    b_to.push_back(t0 + STOP_TICK);
    i_rx = 1'b0;
    tick_n(BC);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      tick_n(BC);
    end
    if (PB != 0) begin
      i_rx = pbit;
      tick_n(BC);
    end
    i_rx = stop;
    tick_n(BC);
    i_rx = 1'b1;
    tick_n(24);
  endtask

  task automatic send_good(logic [7:0] b);
    send_frame(b, 1'b1, ^b);
  endtask

  int         t;
  logic [7:0] ab = 8'h96;

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    u_if.i_ready = 1'b0;
    tick_n(5);
    rst = 1'b0;
    chk_en = 1'b1;
    at_cyc(cyc);
    chk("rst_valid", u_if.o_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", u_if.o_data, 0);
    tick_n(4);

    // Good frame 0xA5; without parity the byte appears 155 cycles in.
    t = cyc;
    fork
      send_good(8'hA5);
      begin
        at_cyc(t + STOP_TICK);
        chk("a5_pre_valid", u_if.o_valid, 0);
        chk("a5_pre_busy", busy, 1);
        at_cyc(t + COMMIT);
        chk("a5_valid", u_if.o_valid, 1);
        chk("a5_data", u_if.o_data, 8'hA5);
        chk("a5_busy", busy, 0);
        chk("a5_fe", fe, 0);
        tick_n(1);
        u_if.i_ready = 1'b1;
        at_cyc(t + COMMIT + 1);
        chk("a5_hs_valid", u_if.o_valid, 1);
        tick_n(1);
        u_if.i_ready = 1'b0;
        at_cyc(t + COMMIT + 2);
        chk("a5_drop_valid", u_if.o_valid, 0);
      end
    join
    if (PB == 0) chk("a5_commit_cycle", COMMIT, 155);

    // 4-cycle glitch: start tick samples high again.
    t = cyc;
    b_from.push_back(t + LOAD + 1);
    b_to.push_back(t + START_TICK);
    i_rx = 1'b0;
    tick_n(4);
    i_rx = 1'b1;
    at_cyc(t + START_TICK);
    chk("gl_busy_hi", busy, 1);
    at_cyc(t + START_TICK + 1);
    chk("gl_busy_lo", busy, 0);
    chk("gl_valid", u_if.o_valid, 0);
    chk("gl_fe", fe, 0);
    tick_n(30);

    // Bad stop bit.
    t = cyc;
    fork
      send_frame(8'h3C, 1'b0, ^(8'h3C));
      begin
        at_cyc(t + COMMIT);
        chk("fe_pulse", fe, 1);
        chk("fe_valid", u_if.o_valid, 0);
        at_cyc(t + COMMIT + 1);
        chk("fe_end", fe, 0);
      end
    join

    // Overrun with i_ready held low.
    send_good(8'h11);
    t = cyc;
    fork
      send_good(8'h22);
      begin
        at_cyc(t + COMMIT);
        chk("ov_pulse", ov, 1);
        chk("ov_data", u_if.o_data, 8'h11);
        chk("ov_valid", u_if.o_valid, 1);
        at_cyc(t + COMMIT + 1);
        chk("ov_end", ov, 0);
      end
    join
    u_if.i_ready = 1'b1;
    at_cyc(cyc);
    chk("ov_hs_valid", u_if.o_valid, 1);
    tick_n(1);
    u_if.i_ready = 1'b0;
    at_cyc(cyc);
    chk("ov_drop_valid", u_if.o_valid, 0);
    tick_n(4);

    // Pending byte, then reset during data bit 3 of the next frame.
    send_good(8'h33);
    t = cyc;
    b_from.push_back(t + LOAD + 1);
    b_to.push_back(t + 100000);
    i_rx = 1'b0;
    tick_n(BC);
    for (int i = 0; i < 3; i++) begin
      i_rx = ab[i];
      tick_n(BC);
    end
    i_rx = ab[3];
    tick_n(8);
    chk("rs_pre_busy", busy, 1);
    rst = 1'b1;
    i_rx = 1'b1;
    tick_n(1);
    rst = 1'b0;
    at_cyc(cyc);
    chk("rs_valid", u_if.o_valid, 0);
    chk("rs_busy", busy, 0);
    chk("rs_data", u_if.o_data, 0);
    tick_n(40);
    t = cyc;
    fork
      send_good(8'h5A);
      begin
        at_cyc(t + COMMIT);
        chk("rs_5a_valid", u_if.o_valid, 1);
        chk("rs_5a_data", u_if.o_data, 8'h5A);
      end
    join
    u_if.i_ready = 1'b1;
    tick_n(3);
    u_if.i_ready = 1'b0;

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones; parity bit 0 is wrong.
    t = cyc;
    fork
      send_frame(8'h07, 1'b1, 1'b0);
      begin
        at_cyc(t + COMMIT);
        chk("par_pulse", pe, 1);
        chk("par_valid", u_if.o_valid, 0);
        chk("par_fe", fe, 0);
      end
    join
`endif

    tick_n(5);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
